// File: rtl/enh_frame_ctrl_if.sv
// Signal bundle between a frame requester, enh_frame_ctrl and the pixel read engine.
// Request side:
//   req_valid/req_ready handshake, with req_op, req_value, req_sign and req_thresh as payload.
//   abort cancels the frame in flight.
// Engine side:
//   eng_start is the one-cycle start pulse; eng_op/value/sign/thresh hold the latched config.
//   eng_vsync/eng_hsync/eng_done are the engine status inputs.
// Status: busy, frame_done, err_timeout, err_count, line_cnt, frame_cnt.
// The slave modport is the controller; master is whoever drives requests and models the engine.
interface enh_frame_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_value;
    logic        req_sign;
    logic [7:0]  req_thresh;
    logic        abort;
    logic        eng_start;
    logic [1:0]  eng_op;
    logic [7:0]  eng_value;
    logic        eng_sign;
    logic [7:0]  eng_thresh;
    logic        eng_vsync;
    logic        eng_hsync;
    logic        eng_done;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;
    logic        err_count;
    logic [9:0]  line_cnt;
    logic [15:0] frame_cnt;

    modport slave (
        input  req_valid, req_op, req_value, req_sign, req_thresh, abort,
        input  eng_vsync, eng_hsync, eng_done,
        output req_ready, eng_start, eng_op, eng_value, eng_sign, eng_thresh,
        output busy, frame_done, err_timeout, err_count, line_cnt, frame_cnt
    );

    modport master (
        output req_valid, req_op, req_value, req_sign, req_thresh, abort,
        output eng_vsync, eng_hsync, eng_done,
        input  req_ready, eng_start, eng_op, eng_value, eng_sign, eng_thresh,
        input  busy, frame_done, err_timeout, err_count, line_cnt, frame_cnt
    );
endinterface

// File: rtl/enh_frame_ctrl.sv
// Frame controller for the image enhancement read engine.
// - Accepts one frame request at a time and latches its configuration onto eng_*.
// - Pulses eng_start for one cycle.
// - Tracks pixel-pair beats and completed lines while the engine streams.
// - Reports good completion, a beat-count error or a watchdog timeout as one-cycle pulses.
// Ports:
//   HCLK    - clock, rising edge.
//   HRESETn - synchronous active-low reset.
//   bus     - enh_frame_ctrl_if.slave carrying request, engine and status signals.
// Every output is driven straight from a flop.
module enh_frame_ctrl #(
    parameter int unsigned WIDTH   = 768,
    parameter int unsigned HEIGHT  = 512,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    enh_frame_ctrl_if.slave    bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_DATA = 3'd2;
    localparam logic [2:0] ACTIVE    = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [17:0] BEATS_PER_FRAME = 18'(WIDTH * HEIGHT / 2);
    localparam logic [9:0]  LINE_MAX        = 10'(HEIGHT);
    localparam logic [15:0] WDOG_MAX        = 16'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [17:0] beat_q, beat_d;
    logic [15:0] wdog_q, wdog_d;
    logic [9:0]  line_q, line_d;
    logic        hsync_q;
    logic        expire;
    logic        done_go;
    logic        frame_done_d, err_count_d, err_timeout_d;

    logic        req_ready_q, busy_q, eng_start_q;
    logic        frame_done_q, err_timeout_q, err_count_q;
    logic [15:0] frame_cnt_q;
    logic [1:0]  eng_op_q;
    logic [7:0]  eng_value_q, eng_thresh_q;
    logic        eng_sign_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        line_d  = line_q;
        expire  = 1'b0;
        done_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) state_d = LOAD;
            end
            LOAD: begin
                beat_d  = '0;
                wdog_d  = '0;
                line_d  = '0;
                state_d = bus.abort ? IDLE : WAIT_DATA;
            end
            WAIT_DATA, ACTIVE: begin
                // The first hsync in WAIT_DATA is beat 1, so counting is shared by both states.
                if (bus.eng_hsync) begin
                    wdog_d = '0;
                    beat_d = beat_q + 18'd1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
                // A falling edge of hsync closes a line.
                if (state_q == ACTIVE && hsync_q && !bus.eng_hsync && line_q < LINE_MAX) begin
                    line_d = line_q + 10'd1;
                end
                expire = !bus.eng_hsync && (wdog_d == WDOG_MAX);
                if (bus.abort || expire) begin
                    state_d = IDLE;
                end else if (state_q == WAIT_DATA) begin
                    if (bus.eng_hsync) state_d = ACTIVE;
                end else if (bus.eng_done) begin
                    state_d = DONE;
                    done_go = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulses land in the cycle the FSM enters DONE / returns to IDLE; abort suppresses all.
    assign err_timeout_d = expire && !bus.abort;
    assign frame_done_d  = done_go && (beat_d == BEATS_PER_FRAME);
    assign err_count_d   = done_go && (beat_d != BEATS_PER_FRAME);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            wdog_q        <= '0;
            line_q        <= '0;
            hsync_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            eng_start_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 1'b0;
            frame_cnt_q   <= '0;
            eng_op_q      <= '0;
            eng_value_q   <= '0;
            eng_sign_q    <= 1'b0;
            eng_thresh_q  <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            wdog_q        <= wdog_d;
            line_q        <= line_d;
            hsync_q       <= bus.eng_hsync;
            // Status flops are loaded from the next state so they line up with state_q.
            req_ready_q   <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            eng_start_q   <= (state_d == LOAD);
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
            frame_cnt_q   <= frame_cnt_q + {15'd0, frame_done_d};
            if (state_q == IDLE && bus.req_valid) begin
                eng_op_q     <= bus.req_op;
                eng_value_q  <= bus.req_value;
                eng_sign_q   <= bus.req_sign;
                eng_thresh_q <= bus.req_thresh;
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_count   = err_count_q;
    assign bus.line_cnt    = line_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.eng_op      = eng_op_q;
    assign bus.eng_value   = eng_value_q;
    assign bus.eng_sign    = eng_sign_q;
    assign bus.eng_thresh  = eng_thresh_q;

endmodule

// File: tb/tb_enh_frame_ctrl.sv
// Directed bench for enh_frame_ctrl with a reduced geometry: 16x8 pixels (64 beats, 8 lines)
// and TIMEOUT=16, which keeps full frames short.
module tb_enh_frame_ctrl;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_start = 0;
    int   n_fdone = 0;
    int   n_ecount = 0;
    int   n_etime = 0;
    int   s_start, s_fdone, s_ecount, s_etime;

    enh_frame_ctrl_if bus ();

    enh_frame_ctrl #(
        .WIDTH   (16),
        .HEIGHT  (8),
        .TIMEOUT (16)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (bus.eng_start)   n_start++;
        if (bus.frame_done)  n_fdone++;
        if (bus.err_count)   n_ecount++;
        if (bus.err_timeout) n_etime++;
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_start  = n_start;
        s_fdone  = n_fdone;
        s_ecount = n_ecount;
        s_etime  = n_etime;
    endtask

    // Offers a request in IDLE and leaves the controller in its first WAIT_DATA cycle.
    task automatic send_req(input logic [1:0] op, input logic [7:0] val, input logic sgn,
                            input logic [7:0] th);
        bus.req_op     = op;
        bus.req_value  = val;
        bus.req_sign   = sgn;
        bus.req_thresh = th;
        bus.req_valid  = 1'b1;
        step();
        bus.req_valid  = 1'b0;
        bus.eng_vsync  = 1'b1;
        check("load_start", 32'(bus.eng_start), 32'd1);
        check("load_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("wait_start", 32'(bus.eng_start), 32'd0);
    endtask

    // Streams lines of bpl beats with a one-cycle gap; the last line is shortened by drop.
    task automatic send_lines(input int nlines, input int bpl, input int drop);
        for (int l = 0; l < nlines; l++) begin
            int n;
            n = (l == nlines - 1) ? bpl - drop : bpl;
            bus.eng_hsync = 1'b1;
            repeat (n) step();
            bus.eng_hsync = 1'b0;
            step();
        end
    endtask

    task automatic finish_frame();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done  = 1'b0;
        bus.eng_vsync = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_value  = '0;
        bus.req_sign   = 1'b0;
        bus.req_thresh = '0;
        bus.abort      = 1'b0;
        bus.eng_vsync  = 1'b0;
        bus.eng_hsync  = 1'b0;
        bus.eng_done   = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("rst_eng_op", 32'(bus.eng_op), 32'd0);
        HRESETn = 1'b1;
        step();
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Good frame: 8 lines x 8 beats
        snap();
        send_req(2'd1, 8'd100, 1'b1, 8'd0);
        check("f1_eng_op", 32'(bus.eng_op), 32'd1);
        check("f1_eng_value", 32'(bus.eng_value), 32'd100);
        check("f1_eng_sign", 32'(bus.eng_sign), 32'd1);
        check("f1_busy", 32'(bus.busy), 32'd1);
        send_lines(8, 8, 0);
        check("f1_line_cnt", 32'(bus.line_cnt), 32'd8);
        finish_frame();
        check("f1_frame_done", 32'(bus.frame_done), 32'd1);
        check("f1_err_count", 32'(bus.err_count), 32'd0);
        check("f1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        check("f1_done_busy", 32'(bus.busy), 32'd1);
        step();
        check("f1_idle_ready", 32'(bus.req_ready), 32'd1);
        check("f1_idle_busy", 32'(bus.busy), 32'd0);
        check("f1_start_pulses", 32'(n_start - s_start), 32'd1);
        check("f1_done_pulses", 32'(n_fdone - s_fdone), 32'd1);

        // One beat short
        snap();
        send_req(2'd2, 8'd0, 1'b0, 8'd0);
        send_lines(8, 8, 1);
        finish_frame();
        check("f2_err_count", 32'(bus.err_count), 32'd1);
        check("f2_frame_done", 32'(bus.frame_done), 32'd0);
        check("f2_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        step();
        check("f2_done_pulses", 32'(n_fdone - s_fdone), 32'd0);
        check("f2_err_pulses", 32'(n_ecount - s_ecount), 32'd1);

        // Ten lines: line_cnt saturates at HEIGHT, beat count is off
        send_req(2'd1, 8'd1, 1'b0, 8'd0);
        send_lines(10, 8, 0);
        check("f3_line_sat", 32'(bus.line_cnt), 32'd8);
        finish_frame();
        check("f3_err_count", 32'(bus.err_count), 32'd1);
        check("f3_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        step();

        // Watchdog: no hsync after start
        snap();
        send_req(2'd3, 8'd0, 1'b0, 8'h55);
        check("to_eng_thresh", 32'(bus.eng_thresh), 32'h55);
        repeat (15) step();
        check("to_early", 32'(bus.err_timeout), 32'd0);
        check("to_early_busy", 32'(bus.busy), 32'd1);
        step();
        check("to_pulse", 32'(bus.err_timeout), 32'd1);
        check("to_ready", 32'(bus.req_ready), 32'd1);
        check("to_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        step();
        check("to_pulse_end", 32'(bus.err_timeout), 32'd0);
        check("to_pulses", 32'(n_etime - s_etime), 32'd1);

        // Second request held during a frame
        send_req(2'd1, 8'd5, 1'b0, 8'd9);
        bus.req_op    = 2'd2;
        bus.req_value = 8'd200;
        bus.req_valid = 1'b1;
        send_lines(4, 8, 0);
        check("hold_ready", 32'(bus.req_ready), 32'd0);
        check("hold_eng_op", 32'(bus.eng_op), 32'd1);
        check("hold_eng_value", 32'(bus.eng_value), 32'd5);
        send_lines(4, 8, 0);
        finish_frame();
        check("hold_frame_done", 32'(bus.frame_done), 32'd1);
        check("hold_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        check("hold_done_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("hold_idle_ready", 32'(bus.req_ready), 32'd1);
        check("hold_idle_op", 32'(bus.eng_op), 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("acc_eng_op", 32'(bus.eng_op), 32'd2);
        check("acc_eng_value", 32'(bus.eng_value), 32'd200);
        check("acc_start", 32'(bus.eng_start), 32'd1);
        step();

        // Abort together with eng_done while ACTIVE
        bus.eng_hsync = 1'b1;
        repeat (3) step();
        snap();
        bus.abort    = 1'b1;
        bus.eng_done = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_hsync = 1'b0;
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_ready", 32'(bus.req_ready), 32'd1);
        check("ab_frame_done", 32'(bus.frame_done), 32'd0);
        check("ab_err_count", 32'(bus.err_count), 32'd0);
        check("ab_err_timeout", 32'(bus.err_timeout), 32'd0);
        check("ab_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        step();
        check("ab_pulses", 32'((n_fdone - s_fdone) + (n_ecount - s_ecount) + (n_etime - s_etime)),
              32'd0);

        // Reset in the middle of ACTIVE
        send_req(2'd3, 8'd7, 1'b1, 8'h20);
        send_lines(2, 8, 0);
        bus.eng_hsync = 1'b1;
        repeat (2) step();
        HRESETn = 1'b0;
        step();
        bus.eng_hsync = 1'b0;
        check("mr_ready", 32'(bus.req_ready), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_eng_op", 32'(bus.eng_op), 32'd0);
        check("mr_eng_value", 32'(bus.eng_value), 32'd0);
        check("mr_eng_sign", 32'(bus.eng_sign), 32'd0);
        check("mr_eng_thresh", 32'(bus.eng_thresh), 32'd0);
        check("mr_line_cnt", 32'(bus.line_cnt), 32'd0);
        check("mr_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("mr_pulses", 32'({bus.eng_start, bus.frame_done, bus.err_count, bus.err_timeout}),
              32'd0);
        HRESETn = 1'b1;
        step();
        check("mr_release_ready", 32'(bus.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
